// File: rtl/apb_mst_bridge.sv
// APB4 requester: turns a valid/ready command into SETUP/ACCESS transfers and
// returns a one-cycle response pulse, aborting if the slave stalls too long.
module apb_mst_bridge #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 5,
    parameter int TIMEOUT   = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_SIZE-1:0]   cmd_addr,
    input  logic [DATA_SIZE-1:0]   cmd_wdata,
    input  logic [DATA_SIZE/8-1:0] cmd_strb,
    output logic                   rsp_valid,
    output logic [DATA_SIZE-1:0]   rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_SIZE-1:0]   PADDR,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [DATA_SIZE-1:0]   PWDATA,
    output logic [DATA_SIZE/8-1:0] PSTRB,
    input  logic                   PREADY,
    input  logic [DATA_SIZE-1:0]   PRDATA,
    input  logic                   PSLVERR
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state;
    logic [CW-1:0] wcnt;
    logic          accept;
    logic          timeout_hit;

    // Ready in ACCESS follows PREADY so a new command can chain onto the completing edge.
    assign cmd_ready   = (state == IDLE) || ((state == ACCESS) && PREADY);
    assign accept      = cmd_valid && cmd_ready;
    assign timeout_hit = (TIMEOUT > 0) && (wcnt == WLAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            wcnt      <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            // Acceptance only happens in IDLE or on a completing ACCESS edge.
            if (accept) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_wdata;
                PSTRB  <= cmd_write ? cmd_strb : '0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= SETUP;
                        PSEL  <= 1'b1;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                    wcnt    <= '0;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        PENABLE   <= 1'b0;
                        if (accept) begin
                            state <= SETUP;
                        end else begin
                            state <= IDLE;
                            PSEL  <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        wcnt <= wcnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_mst_bridge.sv
// Bench for apb_mst_bridge: a memory-backed APB slave with programmable wait
// states, plus a transaction-level model predicting each response and its latency.
module tb_apb_mst_bridge;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_strb = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] PADDR;
    logic          PSEL, PENABLE, PWRITE;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PSTRB;
    logic          PREADY = 1'b0;
    logic [DW-1:0] PRDATA = '0;
    logic          PSLVERR = 1'b0;

    apb_mst_bridge #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int psel_low = 0;
    always @(posedge PCLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Slave side: memory plus programmable wait states / error for the current transfer.
    logic [DW-1:0] slv_mem [32];
    logic [DW-1:0] ref_mem [32];
    int  acnt = 0;
    int  cfg_waits = 0;
    bit  cfg_err = 1'b0;

    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (acnt == cfg_waits) begin
                PREADY  = 1'b1;
                PSLVERR = cfg_err;
                PRDATA  = PWRITE ? $urandom : slv_mem[PADDR];
                if (PWRITE)
                    for (int b = 0; b < 4; b++)
                        if (PSTRB[b]) slv_mem[PADDR][8*b +: 8] = PWDATA[8*b +: 8];
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'($urandom);
                PRDATA  = $urandom;
            end
            acnt++;
        end else begin
            acnt    = 0;
            PREADY  = 1'($urandom);
            PSLVERR = 1'($urandom);
            PRDATA  = $urandom;
        end
    end

    // Response capture and bus-stability checks against the accepted command.
    typedef struct { int c; logic [DW-1:0] d; logic e; } rsp_t;
    rsp_t rq[$];
    logic [AW-1:0] exp_addr = '0;
    logic          exp_w = 1'b0;
    logic [DW-1:0] exp_wdata = '0;
    logic [3:0]    exp_strb = '0;

    always @(negedge PCLK) begin
        if (rsp_valid === 1'b1) rq.push_back('{cyc, rsp_rdata, rsp_err});
        if (PSEL !== 1'b1) psel_low++;
        if (PSEL === 1'b1) begin
            chk("bus_addr", 32'(PADDR), 32'(exp_addr));
            chk("bus_write", 32'(PWRITE), 32'(exp_w));
            chk("bus_wdata", PWDATA, exp_wdata);
            chk("bus_strb", 32'(PSTRB), 32'(exp_strb));
        end
        if (PENABLE === 1'b1) chk("penable_needs_psel", 32'(PSEL), 32'd1);
    end

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] s, input int waits, input bit err, output int acc);
        bit ok;
        ok = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
        for (int n = 0; n < 64; n++) begin
            #1;
            if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge PCLK);
        end
        chk("accept", 32'(ok), 32'd1);
        acc = -1000;
        if (ok) begin @(posedge PCLK); #1; acc = cyc; end
        cmd_valid = 1'b0;
        exp_addr = a; exp_w = w; exp_wdata = d; exp_strb = w ? s : 4'h0;
        cfg_waits = waits; cfg_err = err;
        @(negedge PCLK);
        chk("setup_psel", 32'(PSEL), 32'd1);
        chk("setup_penable", 32'(PENABLE), 32'd0);
    endtask

    // Model: zero-wait takes 2 edges, each wait adds one; TO straight waits abort at edge TO+1.
    task automatic expect_rsp(input string tag, input bit w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [3:0] s,
                              input int waits, input bit err, input int acc);
        bit abort;
        int lat;
        logic [DW-1:0] ed;
        logic ee;
        rsp_t r;
        abort = (waits >= TO);
        lat = abort ? TO + 1 : waits + 2;
        if (abort) begin
            ed = '0; ee = 1'b1;
        end else begin
            ee = err;
            if (w) begin
                ed = '0;
                for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end else begin
                ed = ref_mem[a];
            end
        end
        for (int n = 0; n < 80 && rq.size() == 0; n++) begin @(negedge PCLK); #1; end
        chk({tag, "_seen"}, 32'(rq.size() > 0), 32'd1);
        if (rq.size() > 0) begin
            r = rq.pop_front();
            chk({tag, "_lat"}, 32'(r.c - acc), 32'(lat));
            chk({tag, "_rdata"}, r.d, ed);
            chk({tag, "_err"}, 32'(r.e), 32'(ee));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2, pl;
        bit w, e;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0] s;
        int wt;

        for (int i = 0; i < 32; i++) begin
            d = $urandom; slv_mem[i] = d; ref_mem[i] = d;
        end

        // Reset state, with a command presented that must not be captured.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h1f; cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF;
        repeat (3) @(negedge PCLK);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pstrb", 32'(PSTRB), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
        @(negedge PCLK); PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("post_rst_idle", 32'(PSEL), 32'd0);

        // Zero-wait write, then read back with three wait states.
        issue(1'b1, 5'h03, 32'hDEADBEEF, 4'hF, 0, 1'b0, acc1);
        expect_rsp("wr0", 1'b1, 5'h03, 32'hDEADBEEF, 4'hF, 0, 1'b0, acc1);
        issue(1'b0, 5'h03, 32'h0, 4'hF, 3, 1'b0, acc1);
        expect_rsp("rd3", 1'b0, 5'h03, 32'h0, 4'hF, 3, 1'b0, acc1);

        // Back-to-back writes: PSEL never drops between them.
        issue(1'b1, 5'h07, 32'h1111_2222, 4'h3, 0, 1'b0, acc1);
        pl = psel_low;
        issue(1'b1, 5'h08, 32'h3333_4444, 4'hC, 0, 1'b0, acc2);
        chk("b2b_gap", 32'(acc2 - acc1), 32'd2);
        chk("b2b_psel_held", 32'(psel_low - pl), 32'd0);
        expect_rsp("b2b_1", 1'b1, 5'h07, 32'h1111_2222, 4'h3, 0, 1'b0, acc1);
        expect_rsp("b2b_2", 1'b1, 5'h08, 32'h3333_4444, 4'hC, 0, 1'b0, acc2);

        // Slave error on a read, then a clean transfer clears it.
        issue(1'b0, 5'h07, 32'h0, 4'h0, 1, 1'b1, acc1);
        expect_rsp("slverr", 1'b0, 5'h07, 32'h0, 4'h0, 1, 1'b1, acc1);
        issue(1'b0, 5'h08, 32'h0, 4'h0, 0, 1'b0, acc1);
        expect_rsp("clean", 1'b0, 5'h08, 32'h0, 4'h0, 0, 1'b0, acc1);

        // Timeout abort, then PREADY rising in the last allowed cycle.
        issue(1'b1, 5'h0a, 32'hCAFE_F00D, 4'hF, 100, 1'b0, acc1);
        expect_rsp("abort", 1'b1, 5'h0a, 32'hCAFE_F00D, 4'hF, 100, 1'b0, acc1);
        chk("abort_psel", 32'(PSEL), 32'd0);
        chk("abort_penable", 32'(PENABLE), 32'd0);
        issue(1'b0, 5'h0a, 32'h0, 4'h0, TO - 1, 1'b0, acc1);
        expect_rsp("late_ready", 1'b0, 5'h0a, 32'h0, 4'h0, TO - 1, 1'b0, acc1);

        // Reset during a stalled ACCESS: bus drops asynchronously, no response.
        issue(1'b0, 5'h03, 32'h0, 4'h0, 10, 1'b0, acc1);
        repeat (3) @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        chk("arst_psel", 32'(PSEL), 32'd0);
        chk("arst_penable", 32'(PENABLE), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (5) @(negedge PCLK);
        #1;
        chk("arst_no_rsp", 32'(rq.size()), 32'd0);
        issue(1'b0, 5'h03, 32'h0, 4'h0, 1, 1'b0, acc1);
        expect_rsp("post_arst_rd", 1'b0, 5'h03, 32'h0, 4'h0, 1, 1'b0, acc1);

        // Randomized traffic against the model.
        for (int i = 0; i < 24; i++) begin
            w = 1'($urandom); a = AW'($urandom); d = $urandom; s = 4'($urandom);
            e = ($urandom_range(0, 3) == 0);
            wt = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
            issue(w, a, d, s, wt, e, acc1);
            expect_rsp("rand", w, a, d, s, wt, e, acc1);
        end

        repeat (4) @(negedge PCLK);
        #1;
        chk("no_extra_rsp", 32'(rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_mst_bridge.md
Name: apb_mst_bridge

Overview:
- APB4 requester driving the slave memory and any other APB slave on the same bus.
- Converts a single-command valid/ready request port into APB SETUP/ACCESS sequences.
- Returns read data and error status on a one-cycle response pulse.
- Adds a wait-state timeout so a hung slave cannot stall the requester.

Parameters:
- DATA_SIZE, 32, width of PWDATA/PRDATA and command/response data.
- ADDR_SIZE, 5, width of PADDR and cmd_addr.
- TIMEOUT, 16, maximum consecutive ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  bus clock; all state updates on rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_SIZE  target address.
- cmd_wdata  in  DATA_SIZE  write data.
- cmd_strb  in  DATA_SIZE/8  byte write strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_SIZE  read data; 0 for writes and for aborts.
- rsp_err  out  1  PSLVERR captured, or timeout abort.
- PADDR  out  ADDR_SIZE  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_SIZE  APB write data.
- PSTRB  out  DATA_SIZE/8  APB strobes; forced to 0 on reads.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_SIZE  slave read data.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (PRESETn low, asynchronous):
  - State = IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err and the wait counter = 0.
  - No command is captured while PRESETn is low.
- States:
  - IDLE: PSEL=0, PENABLE=0. cmd_ready=1.
  - SETUP: PSEL=1, PENABLE=0. cmd_ready=0.
  - ACCESS: PSEL=1, PENABLE=1. cmd_ready=PREADY; this is combinational from PREADY and allows back-to-back transfers.
- Acceptance:
  - On an accepted command, register PADDR, PWRITE, PWDATA and PSTRB; PSTRB = cmd_strb if write, else 0.
  - Move to SETUP on that edge.
  - The APB bus signals hold stable from SETUP through the final ACCESS cycle.
- Transitions:
  - SETUP -> ACCESS unconditionally after one cycle.
  - ACCESS with PREADY=0: stay in ACCESS and increment the wait counter.
  - ACCESS with PREADY=1, transfer completes:
    - Next state is SETUP if a new command is accepted on the same edge; PSEL stays 1 and PENABLE drops to 0.
    - Otherwise next state is IDLE and PSEL drops to 0.
- Response:
  - In the cycle after the completing edge: rsp_valid=1 for exactly one cycle.
  - rsp_err = PSLVERR sampled at completion.
  - rsp_rdata = PRDATA sampled at completion for reads, 0 for writes.
  - rsp_rdata and rsp_err hold their values until the next response.
  - The response has no backpressure.
- Latency: zero-wait transfer = SETUP + ACCESS; rsp_valid is high 2 cycles after the acceptance edge. Each slave wait state adds 1 cycle.
- Timeout (TIMEOUT>0):
  - The counter resets to 0 on entry to ACCESS.
  - When PREADY has been low for TIMEOUT consecutive ACCESS cycles, the transfer aborts at the edge ending the TIMEOUT-th such cycle:
    - state -> IDLE; PSEL and PENABLE -> 0.
    - rsp_valid=1, rsp_err=1, rsp_rdata=0 on the next cycle.
    - cmd_ready is 0 on the abort edge; a command presented there is not accepted.
  - If PREADY is high in that same cycle, normal completion wins.
  - Counter width is clog2(TIMEOUT+1).
- PSLVERR is ignored outside the completing ACCESS cycle. PRDATA is ignored for writes.
- Reset mid-transfer: the bus drops immediately and asynchronously, and no response is issued for the interrupted command.

Test Plan:
- Write cmd addr=5'h03, wdata=32'hDEADBEEF, strb=4'hF, PREADY=1 -> SETUP then ACCESS with PADDR=3, PWRITE=1, PSTRB=F; rsp_valid 2 cycles after acceptance; rsp_err=0; rsp_rdata=0.
- Read addr=5'h03, slave returns PRDATA=32'hDEADBEEF after 3 wait states -> ACCESS lasts 4 cycles; PSTRB=0; rsp_rdata=32'hDEADBEEF; rsp_valid high 5 cycles after acceptance.
- Back-to-back: two writes, second cmd_valid held high, PREADY=1 -> PSEL stays high across both transfers; pattern SETUP, ACCESS, SETUP, ACCESS; two rsp_valid pulses 2 cycles apart.
- Read with PSLVERR=1 at completion -> rsp_err=1; rsp_rdata=PRDATA; the next clean transfer returns rsp_err=0.
- TIMEOUT=16, PREADY held low -> abort after 16 ACCESS cycles; PSEL=0; rsp_err=1; rsp_rdata=0. Repeat with PREADY rising in the 16th ACCESS cycle -> normal completion, rsp_err=0.
- Assert PRESETn=0 during ACCESS with wait states -> PSEL and PENABLE go low without waiting for PCLK; no rsp_valid; after release, a new read completes normally.
